// File: rtl/wb_classic_master.sv
// Wishbone B4 classic single-transfer master: takes one read/write command,
// runs one CYC/STB cycle and hands back one response (ACK data, ERR or timeout).
module wb_classic_master #(
    parameter int  ADDR_WIDTH     = 2,
    parameter int  DATA_WIDTH     = 32,
    parameter int  GRANULE        = 8,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int SEL_WIDTH      = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,

    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic                  we_o,
    output logic                  stb_o,
    output logic                  cyc_o,
    input  logic                  ack_i,
    input  logic                  err_i
);

    // The counter only has to reach TIMEOUT_CYCLES-1: the abort happens on the edge
    // that would have taken it to the limit.
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DRAIN,
        RESP
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] count;

    assign cmd_ready_o = (state == IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            count         <= '0;
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
            we_o          <= 1'b0;
            adr_o         <= '0;
            dat_o         <= '0;
            sel_o         <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_dat_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        adr_o <= cmd_adr_i;
                        dat_o <= cmd_dat_i;
                        sel_o <= cmd_sel_i;
                        we_o  <= cmd_we_i;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        count <= '0;
                        state <= BUS;
                    end
                end

                BUS: begin
                    // ERR dominates ACK, and either one beats a timeout on the same edge.
                    if (ack_i || err_i) begin
                        cyc_o         <= 1'b0;
                        stb_o         <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= err_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_dat_o     <= (err_i || we_o) ? '0 : dat_i;
                        state         <= DRAIN;
                    end else if (TIMEOUT_CYCLES != 0 && count == CNT_LIMIT) begin
                        cyc_o         <= 1'b0;
                        stb_o         <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= 1'b0;
                        rsp_timeout_o <= 1'b1;
                        rsp_dat_o     <= '0;
                        state         <= DRAIN;
                    end else begin
                        count <= count + CNT_WIDTH'(1);
                    end
                end

                DRAIN: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o   <= 1'b0;
                        rsp_err_o     <= 1'b0;
                        rsp_timeout_o <= 1'b0;
                    end
                    if (!ack_i && !err_i) begin
                        state <= (rsp_ready_i || !rsp_valid_o) ? IDLE : RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o   <= 1'b0;
                        rsp_err_o     <= 1'b0;
                        rsp_timeout_o <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_classic_master.sv
// Randomised scoreboard bench for wb_classic_master with a reactive Wishbone slave
// and a second instance that has the timeout disabled.
module tb_wb_classic_master;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    typedef enum int {K_ACK, K_ERR, K_BOTH, K_SILENT} kind_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        kind_t         kind;
        int            lat;
        int            hold;
        logic [DW-1:0] rdata;
    } txn_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic          err;
        logic          tmo;
        int            cyc_cycles;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_dat;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w, dat_r;
    logic [SW-1:0] sel;
    logic          we, stb, cyc;
    logic          ack = 1'b0;
    logic          err = 1'b0;

    logic          cmd_valid_nt, cmd_ready_nt, rsp_valid_nt, rsp_err_nt, rsp_timeout_nt;
    logic [DW-1:0] rsp_dat_nt, dat_w_nt;
    logic [AW-1:0] adr_nt;
    logic [SW-1:0] sel_nt;
    logic          we_nt, stb_nt, cyc_nt;
    logic [DW-1:0] zero_dat = '0;
    logic          zero_bit = 1'b0;

    wb_classic_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .adr_o(adr), .dat_o(dat_w), .dat_i(dat_r), .sel_o(sel), .we_o(we),
        .stb_o(stb), .cyc_o(cyc), .ack_i(ack), .err_i(err)
    );

    wb_classic_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT_CYCLES(0)
    ) dut_nt (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_nt), .cmd_ready_o(cmd_ready_nt), .cmd_we_i(zero_bit),
        .cmd_adr_i(AW'(2)), .cmd_dat_i(zero_dat), .cmd_sel_i(SW'(15)),
        .rsp_valid_o(rsp_valid_nt), .rsp_ready_i(1'b1), .rsp_dat_o(rsp_dat_nt),
        .rsp_err_o(rsp_err_nt), .rsp_timeout_o(rsp_timeout_nt),
        .adr_o(adr_nt), .dat_o(dat_w_nt), .dat_i(zero_dat), .sel_o(sel_nt), .we_o(we_nt),
        .stb_o(stb_nt), .cyc_o(cyc_nt), .ack_i(zero_bit), .err_i(zero_bit)
    );

    txn_t slave_q[$];
    rsp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   n_accepted   = 0;
    int   ready_mode   = 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the response and CYC length follow from the slave's behaviour alone.
    function automatic rsp_t model(input txn_t t);
        rsp_t r;
        r.dat = '0;
        r.err = 1'b0;
        r.tmo = 1'b0;
        if (t.kind == K_SILENT || t.lat >= TO) begin
            r.tmo        = 1'b1;
            r.cyc_cycles = TO;
        end else begin
            r.cyc_cycles = t.lat + 1;
            if (t.kind == K_ERR || t.kind == K_BOTH) r.err = 1'b1;
            else if (!t.we)                          r.dat = t.rdata;
        end
        return r;
    endfunction

    function automatic txn_t mk(input logic w, input int a, input logic [DW-1:0] d, input int s,
                                input kind_t k, input int l, input int h, input logic [DW-1:0] rd);
        txn_t t;
        t.we = w; t.adr = AW'(a); t.dat = d; t.sel = SW'(s);
        t.kind = k; t.lat = l; t.hold = h; t.rdata = rd;
        return t;
    endfunction

    // Caller is aligned at posedge+2; returns at posedge+2 just after the accept edge.
    task automatic applyStimulus(input txn_t t);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_we    = t.we;
        cmd_adr   = t.adr;
        cmd_dat   = t.dat;
        cmd_sel   = t.sel;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) begin
            checkOutput("cmd_accept_timeout", cmd_ready, 1);
        end else begin
            slave_q.push_back(t);
            exp_q.push_back(model(t));
            n_accepted++;
        end
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        cmd_dat   = DW'($urandom);
    endtask

    task automatic waitIdle();
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while ((exp_q.size() != 0 || cyc || ack || err) && waited < 300);
        if (waited >= 300) checkOutput("wait_idle_timeout", exp_q.size(), 0);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Slave: answers after lat cycles and keeps ACK/ERR up for hold cycles after CYC drops.
    txn_t cur;
    logic active  = 1'b0;
    logic holding = 1'b0;
    int   nwait   = 0;
    int   hold_left = 0;
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            ack = 1'b0; err = 1'b0; active = 1'b0; holding = 1'b0;
        end else if (holding) begin
            if (hold_left > 0) hold_left--;
            else begin ack = 1'b0; err = 1'b0; holding = 1'b0; end
        end else if (cyc) begin
            if (!active) begin
                if (slave_q.size() == 0) checkOutput("cyc_without_command", cyc, 0);
                else begin cur = slave_q.pop_front(); active = 1'b1; nwait = 0; end
            end
            if (active && cur.kind != K_SILENT && nwait >= cur.lat) begin
                ack   = (cur.kind == K_ACK || cur.kind == K_BOTH);
                err   = (cur.kind == K_ERR || cur.kind == K_BOTH);
                dat_r = cur.rdata;
            end else begin
                dat_r = DW'($urandom);
            end
            nwait++;
        end else if (active) begin
            active = 1'b0;
            if (ack || err) begin
                if (cur.hold > 0) begin holding = 1'b1; hold_left = cur.hold - 1; end
                else begin ack = 1'b0; err = 1'b0; end
            end
        end
    end

    // Monitor: bus stability, CYC length and the response scoreboard.
    int   cyc_count = 0;
    logic prev_cyc  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc_count = 0;
            prev_cyc  = 1'b0;
        end else begin
            checkOutput("stb_eq_cyc", stb, cyc);
            if (holding) checkOutput("stb_while_ack_held", stb, 0);
            if (cyc) begin
                cyc_count++;
                checkOutput("cmd_ready_in_bus", cmd_ready, 0);
                if (active) begin
                    checkOutput("bus_adr", adr, cur.adr);
                    checkOutput("bus_dat", dat_w, cur.dat);
                    checkOutput("bus_sel", sel, cur.sel);
                    checkOutput("bus_we", we, cur.we);
                end
            end
            if (prev_cyc && !cyc) begin
                checkOutput("rsp_valid_with_cyc_drop", rsp_valid, 1);
                if (exp_q.size() == 0) checkOutput("cycle_without_expect", prev_cyc, 0);
                else checkOutput("cyc_high_cycles", cyc_count, exp_q[0].cyc_cycles);
                cyc_count = 0;
            end
            if (rsp_valid) begin
                checkOutput("cmd_ready_while_rsp", cmd_ready, 0);
                if (exp_q.size() == 0) begin
                    checkOutput("rsp_without_command", rsp_valid, 0);
                end else begin
                    checkOutput("rsp_dat", rsp_dat, exp_q[0].dat);
                    checkOutput("rsp_err", rsp_err, exp_q[0].err);
                    checkOutput("rsp_timeout", rsp_timeout, exp_q[0].tmo);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            prev_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        n_mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        int base;
        int hi;
        int waited;
        txn_t t;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; cmd_valid_nt = 1'b0; dat_r = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_cyc", cyc, 0);
        checkOutput("reset_stb", stb, 0);
        checkOutput("reset_we", we, 0);
        checkOutput("reset_adr", adr, 0);
        checkOutput("reset_dat", dat_w, 0);
        checkOutput("reset_sel", sel, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_rsp_timeout", rsp_timeout, 0);
        checkOutput("reset_rsp_dat", rsp_dat, 0);
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        applyStimulus(mk(1'b1, 1, 32'hDEADBEEF, 15, K_ACK, 1, 1, 32'hA5A5A5A5));
        applyStimulus(mk(1'b0, 2, 32'h0, 15, K_ACK, 0, 0, 32'h12345678));
        applyStimulus(mk(1'b0, 3, 32'h0, 15, K_ERR, 0, 1, 32'h77777777));
        applyStimulus(mk(1'b0, 0, 32'h0, 3, K_SILENT, 0, 0, 32'h0));
        applyStimulus(mk(1'b0, 1, 32'h0, 12, K_ACK, TO - 1, 0, 32'hCAFEF00D));
        applyStimulus(mk(1'b1, 2, 32'h01020304, 1, K_ACK, TO, 0, 32'h0));
        applyStimulus(mk(1'b1, 3, 32'h55AA55AA, 6, K_BOTH, 2, 2, 32'h99999999));
        waitIdle();

        ready_mode = 0;
        base = n_accepted;
        fork
            begin
                applyStimulus(mk(1'b0, 1, 32'h0, 15, K_ACK, 1, 0, 32'h13572468));
                applyStimulus(mk(1'b1, 0, 32'hFEEDFACE, 15, K_ACK, 0, 0, 32'h0));
            end
            begin
                waited = 0;
                do begin
                    @(negedge clk);
                    waited++;
                end while (!rsp_valid && waited < 50);
                repeat (10) @(negedge clk);
                checkOutput("second_cmd_held_off", n_accepted - base, 1);
                ready_mode = 1;
            end
        join
        waitIdle();

        applyStimulus(mk(1'b0, 2, 32'h0, 15, K_SILENT, 0, 0, 32'h0));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_cyc", cyc, 0);
        checkOutput("async_reset_stb", stb, 0);
        checkOutput("async_reset_rsp_valid", rsp_valid, 0);
        checkOutput("async_reset_cmd_ready", cmd_ready, 1);
        slave_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(mk(1'b0, 3, 32'h0, 15, K_ACK, 2, 0, 32'h0BADF00D));
        waitIdle();

        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            t.we    = 1'($urandom);
            t.adr   = AW'($urandom);
            t.dat   = DW'($urandom);
            t.sel   = SW'($urandom_range(1, 15));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: t.kind = K_ACK;
                6, 7:             t.kind = K_ERR;
                8:                t.kind = K_BOTH;
                default:          t.kind = K_SILENT;
            endcase
            t.lat   = $urandom_range(0, 5);
            t.hold  = $urandom_range(0, 2);
            t.rdata = DW'($urandom);
            applyStimulus(t);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end
        waitIdle();
        ready_mode = 1;

        cmd_valid_nt = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!cmd_ready_nt && waited < 20);
        checkOutput("no_timeout_accept", cmd_ready_nt, 1);
        @(posedge clk);
        #2;
        cmd_valid_nt = 1'b0;
        hi = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cyc_nt) hi++;
        end
        checkOutput("no_timeout_cyc_cycles", hi, 1000);
        checkOutput("no_timeout_rsp_valid", rsp_valid_nt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
